// File: rtl/fpf_stream_decoder_03.sv
// Receive-side decoder for the forbidden-pattern-free TSV link: 101/010 screening, FNS-weighted
// binary conversion, 2-stage valid/ready pipeline. Define FPF_DEC_ERRCNT_EN to add err_count.
module fpf_stream_decoder_03 #(
    parameter int NTSV = 3,
    parameter int DW   = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tsv_valid,
    output logic            tsv_ready,
    input  logic [NTSV-1:0] tsv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   dataout,
    output logic            pat_err
`ifdef FPF_DEC_ERRCNT_EN
    ,
    output logic [15:0]     err_count
`endif
);

    // Fibonacci weights: w[0] = w[1] = 1, w[k] = w[k-1] + w[k-2].
    function automatic int fib_weight(input int k);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int i = 2; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    logic            s1_valid;
    logic [NTSV-1:0] s1_tsv;
    logic            s1_err;
    logic            in_err;
    logic [DW-1:0]   s1_sum;
    logic            s2_load;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        in_err = 1'b0;
        for (int j = 0; j <= NTSV - 3; j++) begin
            if (tsv[j +: 3] == 3'b101 || tsv[j +: 3] == 3'b010) begin
                in_err = 1'b1;
            end
        end
    end

    always_comb begin
        s1_sum = '0;
        for (int k = 0; k < NTSV; k++) begin
            if (s1_tsv[k]) begin
                s1_sum = s1_sum + DW'(fib_weight(k));
            end
        end
    end

    // S2 frees up when empty or drained this cycle; S1 can then refill in the same cycle.
    assign s2_load   = !out_valid || out_ready;
    assign tsv_ready = !reset && (!s1_valid || s2_load);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, giving true pipeline behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_tsv    <= '0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            dataout   <= '0;
            pat_err   <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    dataout <= s1_sum;
                    pat_err <= s1_err;
                end
            end
            if (tsv_ready) begin
                s1_valid <= tsv_valid;
                if (tsv_valid) begin
                    s1_tsv <= tsv;
                    s1_err <= in_err;
                end
            end
        end
    end

`ifdef FPF_DEC_ERRCNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_valid && out_ready && pat_err && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpf_stream_decoder_03.sv
// Directed self-checking bench for fpf_stream_decoder_03 (NTSV = 3, DW = 3).
module tb_fpf_stream_decoder_03;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tsv_valid = 1'b0;
    logic       tsv_ready;
    logic [2:0] tsv = 3'b000;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] dataout;
    logic       pat_err;
`ifdef FPF_DEC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int tests = 0;
    int fails = 0;

    // Hand-derived FNS values (weights 1,1,2) indexed by the 3-bit word.
    logic [2:0] dec_tab [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    logic [2:0] legal_w [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b111};
    logic [3:0] sb [$];  // {pat_err, dataout} of accepted words, oldest first

    fpf_stream_decoder_03 #(.NTSV(3), .DW(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .tsv_valid (tsv_valid),
        .tsv_ready (tsv_ready),
        .tsv       (tsv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .pat_err   (pat_err)
`ifdef FPF_DEC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // One cycle: drive at the falling edge, observe just after, then wait for the rising edge.
    // Accepted words are pushed onto the scoreboard with their expected output.
    task automatic step(input logic v, input logic [2:0] w, input logic ordy,
                        output logic acc, output logic rdy, output logic con,
                        output logic [2:0] od, output logic oe);
        @(negedge clock);
        tsv_valid = v;
        tsv       = w;
        out_ready = ordy;
        #1;
        rdy = tsv_ready;
        acc = v && tsv_ready;
        con = out_valid && out_ready;
        od  = dataout;
        oe  = pat_err;
        if (acc) sb.push_back({(w == 3'b010 || w == 3'b101), dec_tab[w]});
        @(posedge clock);
    endtask

    task automatic test_reset();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        reset = 1'b1;
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (rdy !== 1'b0 || out_valid !== 1'b0 || od !== 3'd0 || oe !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b valid=%b data=%0d err=%b, required 0 0 0 0",
                     rdy, out_valid, od, oe);
        end
        reset = 1'b0;
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (rdy !== 1'b1 || con !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", rdy, con);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        logic bad;
        step(1'b1, 3'b111, 1'b0, acc, rdy, con, od, oe);
        step(1'b1, 3'b110, 1'b0, acc, rdy, con, od, oe);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b000, 1'b0, acc, rdy, con, od, oe);
            if (rdy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_midstream_hold: ready_seen_high=%b valid=%b, required 0 0", bad, out_valid);
        end
        reset = 1'b0;
        sb.delete();
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b0 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_midstream_after: valid=%b ready=%b, required valid=0 ready=1", con, rdy);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
            if (con) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_midstream_stale: stale output seen=%b, required 0", bad);
        end
    endtask

    // Send one word alone and check the output appears exactly two cycles after the transfer.
    task automatic send_single(input string name, input logic [2:0] w,
                               input logic [2:0] exp_d, input logic exp_e);
        logic acc, rdy, con, oe;
        logic [2:0] od;
        step(1'b1, w, 1'b1, acc, rdy, con, od, oe);
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b0) begin
            fails++;
            $display("FAIL %s_early: valid=%b one cycle after transfer, required 0", name, con);
        end
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b1 || od !== exp_d || oe !== exp_e) begin
            fails++;
            $display("FAIL %s: tsv=%b valid=%b data=%0d err=%b, required valid=1 data=%0d err=%b",
                     name, w, con, od, oe, exp_d, exp_e);
        end
        sb.delete();
    endtask

    task automatic test_legal();
        logic [2:0] exp_d [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 6; i++) send_single("legal", legal_w[i], exp_d[i], 1'b0);
    endtask

    task automatic test_forbidden();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        send_single("forbid_101", 3'b101, 3'd3, 1'b1);
        send_single("forbid_010", 3'b010, 3'd1, 1'b1);
`ifdef FPF_DEC_ERRCNT_EN
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (err_count !== 16'd2) begin
            fails++;
            $display("FAIL err_count_two: got %0d, required 2", err_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        step(1'b1, 3'b111, 1'b0, acc, rdy, con, od, oe);
        step(1'b1, 3'b000, 1'b0, acc, rdy, con, od, oe);
        tests++;
        if (acc !== 1'b1) begin
            fails++;
            $display("FAIL bp_second_accept: accepted=%b, required 1", acc);
        end
        step(1'b1, 3'b011, 1'b0, acc, rdy, con, od, oe);
        tests++;
        if (rdy !== 1'b0 || out_valid !== 1'b1 || od !== 3'd4) begin
            fails++;
            $display("FAIL bp_full: ready=%b valid=%b data=%0d, required ready=0 valid=1 data=4",
                     rdy, out_valid, od);
        end
        step(1'b1, 3'b011, 1'b0, acc, rdy, con, od, oe);
        tests++;
        if (rdy !== 1'b0 || od !== 3'd4) begin
            fails++;
            $display("FAIL bp_hold: ready=%b data=%0d, required ready=0 data=4", rdy, od);
        end
        step(1'b1, 3'b011, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b1 || od !== 3'd4 || acc !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_0: out=%b data=%0d accepted=%b, required 1 4 1", con, od, acc);
        end
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b1 || od !== 3'd0) begin
            fails++;
            $display("FAIL bp_release_1: out=%b data=%0d, required 1 0", con, od);
        end
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b1 || od !== 3'd2) begin
            fails++;
            $display("FAIL bp_release_2: out=%b data=%0d, required 1 2", con, od);
        end
        step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (con !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_extra: out=%b, required 0", con);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        logic [2:0] words [4] = '{3'b110, 3'b001, 3'b111, 3'b100};
        logic [2:0] exp_d [4] = '{3'd3, 3'd1, 3'd4, 3'd2};
        logic all_acc;
        all_acc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? words[i] : 3'b000, 1'b1, acc, rdy, con, od, oe);
            if (i < 4 && !acc) all_acc = 1'b0;
            if (i >= 2) begin
                tests++;
                if (con !== 1'b1 || od !== exp_d[i-2]) begin
                    fails++;
                    $display("FAIL b2b_out_%0d: out=%b data=%0d, required 1 %0d", i - 2, con, od, exp_d[i-2]);
                end
            end
        end
        tests++;
        if (!all_acc) begin
            fails++;
            $display("FAIL b2b_accept: a word was refused, required 1 word per cycle");
        end
        sb.delete();
    endtask

    task automatic test_random();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        logic [2:0] w;
        logic       v;
        logic [3:0] exp;
        int sent, errs;
        sent = 0;
        errs = 0;
        v = 1'b0;
        w = 3'b000;
        while (sent < 1000) begin
            if (!v) begin
                v = ($urandom_range(0, 3) != 0);
                w = legal_w[$urandom_range(0, 5)];
            end
            step(v, w, ($urandom_range(0, 2) != 0), acc, rdy, con, od, oe);
            if (con) begin
                if (sb.size() == 0) errs++;
                else begin
                    exp = sb.pop_front();
                    if ({oe, od} !== exp) errs++;
                end
            end
            if (acc) begin
                sent++;
                v = 1'b0;
            end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
            if (con) begin
                exp = sb.pop_front();
                if ({oe, od} !== exp) errs++;
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL random_data: %0d wrong outputs, required 0", errs);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL random_loss: %0d words never emerged, required 0", sb.size());
        end
        sb.delete();
    endtask

`ifdef FPF_DEC_ERRCNT_EN
    task automatic test_saturation();
        logic acc, rdy, con, oe;
        logic [2:0] od;
        for (int i = 0; i < 70000; i++) step(1'b1, 3'b101, 1'b1, acc, rdy, con, od, oe);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b1, acc, rdy, con, od, oe);
        tests++;
        if (err_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL err_count_sat: got %0d, required 65535", err_count);
        end
        sb.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midstream();
        test_legal();
        test_forbidden();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef FPF_DEC_ERRCNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
